// File: rtl/serial_word_transmitter.sv
// Serial frame transmitter. Each frame is a start bit, the data bits LSB first, an optional
// even-parity bit and then the stop bits. A word is accepted on a one-cycle start strobe while idle.
module serial_word_transmitter #(
  parameter int WORD_SIZE    = 4,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 tx,
  output logic [WORD_SIZE-1:0] last_word
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WORD_SIZE + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg;
  logic [BIT_W-1:0]     bit_reg;
  logic [WORD_SIZE-1:0] shift_reg;
  logic [WORD_SIZE-1:0] word_reg;
  logic [WORD_SIZE-1:0] last_word_reg;
  logic                 parity_reg;
  logic                 done_reg;
  logic                 bit_end;

  assign bit_end = (baud_reg == BAUD_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = START;
      START:  if (bit_end) state_next = DATA;
      DATA:   if (bit_end && (bit_reg == DATA_LAST)) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end && (bit_reg == STOP_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, shift register and the done/last_word bookkeeping. The baud counter is held at
  // zero while idle so the first bit edge lines up exactly with start acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_reg      <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      word_reg      <= '0;
      last_word_reg <= '0;
      parity_reg    <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        baud_reg <= '0;
        bit_reg  <= '0;
        if (start) begin
          shift_reg  <= data_in;
          word_reg   <= data_in;
          parity_reg <= ^data_in;
        end
      end else begin
        baud_reg <= bit_end ? '0 : baud_reg + BAUD_W'(1);
        if (bit_end) begin
          // bit_reg counts data bits in DATA and stop bits in STOP; restart it on every state change.
          bit_reg <= (state_next != state_reg) ? '0 : bit_reg + BIT_W'(1);
          if (state_reg == DATA) begin
            shift_reg <= shift_reg >> 1;
          end
        end
        if ((state_reg == STOP) && (state_next == IDLE)) begin
          done_reg      <= 1'b1;
          last_word_reg <= word_reg;
        end
      end
    end
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state_reg != IDLE);
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      PARITY:  tx = parity_reg;
      default: tx = 1'b1;
    endcase
  end

  assign done      = done_reg;
  assign last_word = last_word_reg;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Directed bench for serial_word_transmitter: a parity instance and a no-parity instance,
// with a word scoreboard and per-cycle checks of tx/busy/done across every frame.
module tb_serial_word_transmitter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] data_in;
  logic       start0, start1;
  logic       busy0, done0, tx0;
  logic       busy1, done1, tx1;
  logic [3:0] lw0, lw1;

  int checks = 0;
  int passed = 0;
  logic [3:0] exp_q[$];

  always #5 clock = ~clock;

  serial_word_transmitter dut0 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .start(start0),
    .busy(busy0), .done(done0), .tx(tx0), .last_word(lw0)
  );

  serial_word_transmitter #(.PARITY_EN(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .start(start1),
    .busy(busy1), .done(done1), .tx(tx1), .last_word(lw1)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected line level at cycle i of a frame (i=0 is the first start-bit cycle).
  function automatic logic exp_bit(input logic [3:0] w, input int i, input bit pe);
    int slot;
    slot = i / 10;
    if (slot == 0) return 1'b0;
    if (slot <= 4) return w[slot-1];
    if (pe && slot == 5) return ^w;
    return 1'b1;
  endfunction

  task automatic start_word(input bit sel, input logic [3:0] w);
    data_in = w;
    if (sel) start1 = 1'b1;
    else start0 = 1'b1;
    exp_q.push_back(w);
    @(negedge clock);
    start0  = 1'b0;
    start1  = 1'b0;
    data_in = ~w;
  endtask

  // Checks a whole frame cycle by cycle and leaves the bench in the done cycle.
  task automatic frame_check(input bit sel, input int inject_at);
    logic [3:0] w;
    int len;
    chk("sb_nonempty", 16'(exp_q.size() != 0), 16'd1);
    w   = (exp_q.size() != 0) ? exp_q.pop_front() : 4'h0;
    len = sel ? 60 : 70;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("tx%0d[%0d]", sel, i), sel ? tx1 : tx0, exp_bit(w, i, !sel));
      chk($sformatf("busy%0d[%0d]", sel, i), sel ? busy1 : busy0, 1'b1);
      chk($sformatf("done%0d[%0d]", sel, i), sel ? done1 : done0, 1'b0);
      if (i == inject_at) begin
        data_in = 4'hF;
        start0  = 1'b1;
      end else if (i == inject_at + 1) begin
        start0 = 1'b0;
      end
      @(negedge clock);
    end
    chk($sformatf("done%0d_end", sel), sel ? done1 : done0, 1'b1);
    chk($sformatf("busy%0d_end", sel), sel ? busy1 : busy0, 1'b0);
    chk($sformatf("tx%0d_end", sel), sel ? tx1 : tx0, 1'b1);
    chk($sformatf("last_word%0d", sel), sel ? lw1 : lw0, w);
    $display("frame dut%0d word=%h len=%0d", sel, w, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] dropped;
    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    data_in = 4'h0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      chk("idle_tx0", tx0, 1'b1);
      chk("idle_busy0", busy0, 1'b0);
      chk("idle_done0", done0, 1'b0);
      chk("idle_lw0", lw0, 4'h0);
      chk("idle_tx1", tx1, 1'b1);
      @(negedge clock);
    end

    start_word(0, 4'b1011);
    frame_check(0, -1);
    @(negedge clock);
    chk("done_one_cycle", done0, 1'b0);

    start_word(0, 4'b0000);
    frame_check(0, -1);
    @(negedge clock);

    start_word(1, 4'b0000);
    frame_check(1, -1);
    @(negedge clock);
    start_word(1, 4'b1101);
    frame_check(1, -1);
    @(negedge clock);

    // start during a frame must be ignored and must not queue a second frame
    start_word(0, 4'b1011);
    frame_check(0, 29);
    @(negedge clock);
    for (int i = 0; i < 12; i++) begin
      chk("no_requeue_busy", busy0, 1'b0);
      chk("no_requeue_done", done0, 1'b0);
      chk("no_requeue_tx", tx0, 1'b1);
      @(negedge clock);
    end

    // back-to-back: second start coincides with done
    start_word(0, 4'b0110);
    frame_check(0, -1);
    start_word(0, 4'b1001);
    frame_check(0, -1);
    @(negedge clock);

    // asynchronous reset in the middle of the data bits
    start_word(0, 4'b1011);
    repeat (34) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_lw", lw0, 4'h0);
    dropped = exp_q.pop_front();
    chk("rst_dropped_word", dropped, 4'b1011);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_tx", tx0, 1'b1);
      chk("post_rst_busy", busy0, 1'b0);
      @(negedge clock);
    end
    start_word(0, 4'b0101);
    frame_check(0, -1);
    @(negedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_transmitter.md
Name: serial_word_transmitter

Overview:
Serial line stage that consumes words popped from the accumulation FIFO and shifts each one out as an asynchronous serial frame. A frame is one start bit, then the data bits LSB first, then an optional even-parity bit, then the stop bits. The block sits directly downstream of the FIFO and its IDLE/LOAD/TRANSMIT sequencer. It accepts a word on a one-cycle start strobe and reports busy while the frame is in flight. It also holds the last transmitted word for display.

Parameters:
WORD_SIZE, 4, data bits per frame (1..16).
CLKS_PER_BIT, 10, clock cycles per serial bit (>=2); 5208 for 9600 baud at 50 MHz.
PARITY_EN, 1, 1 = append even-parity bit; 0 = no parity bit.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clock  input  1  system clock, all logic on rising edge.
reset_n  input  1  asynchronous reset, active-low; the clock is single and the reset is asynchronous active-low.
data_in  input  WORD_SIZE  word to send; sampled only in the cycle start is accepted.
start  input  1  one-cycle request to send data_in.
busy  output  1  high from the cycle after an accepted start until the end of the frame.
done  output  1  one-cycle pulse in the first idle cycle after the last stop bit.
tx  output  1  serial line; idles high.
last_word  output  WORD_SIZE  copy of the most recently completed frame's data.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, tx=1, busy=0, done=0, last_word=0, bit counter=0, baud counter=0, shift register=0. tx returns high immediately, even in the middle of a frame. No partial frame resumes after reset.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0.
  - If start=1, the word is latched into the shift register, parity is computed as XOR of data_in, and the next state is START.
  - Acceptance latency: tx falls and busy rises in the cycle after start is sampled.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After WORD_SIZE bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx=latched XOR of data (even parity: total ones in data plus parity is even) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
  - On that transition, done=1 for one cycle, busy=0 in the same cycle, and last_word is updated.
- Frame length: (1 + WORD_SIZE + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles from the first tx=0 cycle to the first IDLE cycle.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT). It is cleared on start acceptance so that bit edges align to the start.
- start while busy=1 is ignored: no queueing, no effect on the frame in flight.
- start in the cycle done=1 (back-to-back): state is IDLE, so the word is accepted. The next start bit begins the following cycle, giving exactly one idle tx=1 cycle between frames.
- data_in changes after acceptance do not affect the frame in flight.
- busy is a registered output with no combinational path from start. The upstream sequencer waits for busy=0 before popping the FIFO.

Test Plan:
- Reset then idle 20 cycles -> tx=1, busy=0, done=0, last_word=0 throughout.
- Defaults, data_in=4'b1011, start pulse at cycle T, expected frame:
  - tx=0 during T+1..T+10.
  - Then data bits 1,1,0,1 at 10 cycles each.
  - Then parity bit 1, then stop bit 1.
  - busy high T+1..T+70; done=1 at T+71; last_word=4'b1011.
- data_in=4'b0000 with PARITY_EN=1 -> parity bit 0. With PARITY_EN=0 -> frame is 60 cycles and no parity slot exists.
- start asserted again at T+30 with data_in=4'b1111 during a frame -> ignored; frame still carries 1011; done pulses exactly once.
- start held coincident with done -> second frame's start bit begins the cycle after done; gap is one tx=1 cycle.
- reset_n pulled low at T+35 (mid-DATA) -> tx=1 and busy=0 asynchronously. After release, a new start sends a complete, correct frame.
